// File: rtl/reorder_buffer_pkg.sv
// Shared CPU types for the reorder buffer: per-entry instruction state,
// exception record, the ROB entry layout and the default ROB depth.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;

  typedef enum logic [1:0] {
    Inst_Invalid  = 2'd0,
    Inst_Wait     = 2'd1,
    Inst_Complete = 2'd2
  } inst_state_e;

  typedef struct packed {
    logic       ex;
    logic [4:0] code;
  } exception_t;

  typedef struct packed {
    inst_state_e state;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        is_store;
    exception_t  exception;
  } rob_entry_t;

  function automatic logic is_occupied(input rob_entry_t e);
    return e.state != Inst_Invalid;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle.
//   dispatch : ds_to_rob_valid, map_to_rob_bus1/2 in; rob_tail_o, rob_ready out
//   complete : cmplN_valid, cmplN_num in
//   retire   : commitN_valid, commitN_entry, flush_o, flush_exception out
// master = pipeline side, slave = reorder buffer.
interface reorder_buffer_if #(
  parameter int ROB_IDX_W = 4
);
  import reorder_buffer_pkg::*;

  logic                 ds_to_rob_valid;
  rob_entry_t           map_to_rob_bus1;
  rob_entry_t           map_to_rob_bus2;
  logic [ROB_IDX_W-1:0] rob_tail_o;
  logic                 rob_ready;

  logic                 cmpl1_valid;
  logic                 cmpl2_valid;
  logic [ROB_IDX_W-1:0] cmpl1_num;
  logic [ROB_IDX_W-1:0] cmpl2_num;

  logic                 commit1_valid;
  logic                 commit2_valid;
  rob_entry_t           commit1_entry;
  rob_entry_t           commit2_entry;
  logic                 flush_o;
  exception_t           flush_exception;

  modport master (
    output ds_to_rob_valid, map_to_rob_bus1, map_to_rob_bus2,
    output cmpl1_valid, cmpl2_valid, cmpl1_num, cmpl2_num,
    input  rob_tail_o, rob_ready,
    input  commit1_valid, commit2_valid, commit1_entry, commit2_entry,
    input  flush_o, flush_exception
  );

  modport slave (
    input  ds_to_rob_valid, map_to_rob_bus1, map_to_rob_bus2,
    input  cmpl1_valid, cmpl2_valid, cmpl1_num, cmpl2_num,
    output rob_tail_o, rob_ready,
    output commit1_valid, commit2_valid, commit1_entry, commit2_entry,
    output flush_o, flush_exception
  );

endinterface

// File: rtl/reorder_buffer_commit_sel.sv
// Combinational retirement selection for the two oldest ROB entries.
//   in : head/next state, store flag and exception of head and head+1
//   out: commit1_valid, commit2_valid, flush, flush_exception, commit_cnt
// An excepting head retires alone and raises flush; two stores never retire
// together so the store path only ever sees one per cycle.
module reorder_buffer_commit_sel
  import reorder_buffer_pkg::*;
(
  input  inst_state_e head_state,
  input  logic        head_store,
  input  exception_t  head_exc,
  input  inst_state_e next_state,
  input  logic        next_store,
  input  logic        next_ex,
  output logic        commit1_valid,
  output logic        commit2_valid,
  output logic        flush,
  output exception_t  flush_exception,
  output logic [1:0]  commit_cnt
);

  always_comb begin
    commit1_valid   = 1'b0;
    commit2_valid   = 1'b0;
    flush           = 1'b0;
    flush_exception = '0;
    commit_cnt      = 2'd0;

    if (head_state == Inst_Complete) begin
      commit1_valid = 1'b1;
      commit_cnt    = 2'd1;
      if (head_exc.ex) begin
        flush           = 1'b1;
        flush_exception = head_exc;
      end else if (next_state == Inst_Complete && !next_ex &&
                   !(head_store && next_store)) begin
        commit2_valid = 1'b1;
        commit_cnt    = 2'd2;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Two-wide in-order reorder buffer.
//   clk, resetn : clock, asynchronous active-low reset
//   rob         : slave side of reorder_buffer_if (dispatch, completion,
//                 commit and flush signals)
// Entries live in a circular array; head retires, tail allocates. Commit
// decisions use registered entry state only, so a completion strobe is
// visible to retirement one cycle later.
module reorder_buffer #(
  parameter int ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
  parameter int ROB_IDX_W = 4
) (
  input  logic            clk,
  input  logic            resetn,
  reorder_buffer_if.slave rob
);
  import reorder_buffer_pkg::rob_entry_t;
  import reorder_buffer_pkg::exception_t;
  import reorder_buffer_pkg::is_occupied;
  import reorder_buffer_pkg::Inst_Invalid;
  import reorder_buffer_pkg::Inst_Wait;
  import reorder_buffer_pkg::Inst_Complete;

  // ready means at least two free slots, i.e. count <= ROB_DEPTH-2
  localparam logic [ROB_IDX_W:0] READY_LIMIT = (ROB_IDX_W+1)'(ROB_DEPTH - 2);

  rob_entry_t           entries [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head;
  logic [ROB_IDX_W-1:0] tail;
  logic [ROB_IDX_W:0]   count;

  logic [ROB_IDX_W-1:0] head_nxt1;
  logic [ROB_IDX_W-1:0] tail_nxt1;
  logic                 rob_ready;
  logic                 disp_fire;
  logic                 disp1;
  logic                 disp2;
  logic [1:0]           disp_cnt;

  logic                 commit1_valid;
  logic                 commit2_valid;
  logic                 flush;
  exception_t           flush_exc;
  logic [1:0]           commit_cnt;

  assign head_nxt1 = head + ROB_IDX_W'(1);
  assign tail_nxt1 = tail + ROB_IDX_W'(1);
  assign rob_ready = (count <= READY_LIMIT);

  // a flushing cycle swallows any dispatch offered alongside it
  assign disp_fire = rob.ds_to_rob_valid & rob_ready & ~flush;
  assign disp1     = disp_fire & is_occupied(rob.map_to_rob_bus1);
  assign disp2     = disp_fire & is_occupied(rob.map_to_rob_bus2);
  assign disp_cnt  = {1'b0, disp1} + {1'b0, disp2};

  reorder_buffer_commit_sel u_commit_sel (
    .head_state      (entries[head].state),
    .head_store      (entries[head].is_store),
    .head_exc        (entries[head].exception),
    .next_state      (entries[head_nxt1].state),
    .next_store      (entries[head_nxt1].is_store),
    .next_ex         (entries[head_nxt1].exception.ex),
    .commit1_valid   (commit1_valid),
    .commit2_valid   (commit2_valid),
    .flush           (flush),
    .flush_exception (flush_exc),
    .commit_cnt      (commit_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // completion only promotes waiting entries; strobes at free slots vanish
      if (rob.cmpl1_valid && entries[rob.cmpl1_num].state == Inst_Wait)
        entries[rob.cmpl1_num].state <= Inst_Complete;
      if (rob.cmpl2_valid && entries[rob.cmpl2_num].state == Inst_Wait)
        entries[rob.cmpl2_num].state <= Inst_Complete;

      if (commit1_valid) entries[head].state      <= Inst_Invalid;
      if (commit2_valid) entries[head_nxt1].state <= Inst_Invalid;

      // dispatch targets are free slots, never the ones retiring or completing
      if (disp1) entries[tail]      <= rob.map_to_rob_bus1;
      if (disp2) entries[tail_nxt1] <= rob.map_to_rob_bus2;

      head  <= head + ROB_IDX_W'(commit_cnt);
      tail  <= tail + ROB_IDX_W'(disp_cnt);
      count <= count + (ROB_IDX_W+1)'(disp_cnt) - (ROB_IDX_W+1)'(commit_cnt);
    end
  end

  assign rob.rob_tail_o      = tail;
  assign rob.rob_ready       = rob_ready;
  assign rob.commit1_valid   = commit1_valid;
  assign rob.commit2_valid   = commit2_valid;
  assign rob.commit1_entry   = entries[head];
  assign rob.commit2_entry   = entries[head_nxt1];
  assign rob.flush_o         = flush;
  assign rob.flush_exception = flush_exc;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn && !flush) begin
      a_dispatch_not_ready: assert (!(rob.ds_to_rob_valid && !rob_ready &&
                                      is_occupied(rob.map_to_rob_bus1)))
        else $warning("reorder_buffer: dispatch offered while not ready, dropped");
      a_bus2_needs_bus1: assert (!(rob.ds_to_rob_valid &&
                                   is_occupied(rob.map_to_rob_bus2) &&
                                   !is_occupied(rob.map_to_rob_bus1)))
        else $error("reorder_buffer: bus2 occupied with bus1 empty");
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_IDX_W(4)) rob_bus ();

  reorder_buffer #(.ROB_DEPTH(16), .ROB_IDX_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rob    (rob_bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q [$];
  logic [3:0]  cmpl_q [$];
  int          m_count = 0;
  logic [3:0]  m_head = '0;
  logic [3:0]  m_tail = '0;
  bit          mon_en = 1'b0;
  logic [31:0] mon_exp;

  function automatic rob_entry_t mk(input logic [31:0] pc, input inst_state_e st,
                                    input logic ex, input logic store);
    rob_entry_t e;
    e = '0;
    e.state = st;
    e.pc = pc;
    e.rd = pc[6:2];
    e.is_store = store;
    e.exception.ex = ex;
    e.exception.code = ex ? 5'd3 : 5'd0;
    return e;
  endfunction

  task automatic idle();
    rob_bus.ds_to_rob_valid = 1'b0;
    rob_bus.map_to_rob_bus1 = '0;
    rob_bus.map_to_rob_bus2 = '0;
    rob_bus.cmpl1_valid = 1'b0;
    rob_bus.cmpl2_valid = 1'b0;
    rob_bus.cmpl1_num = '0;
    rob_bus.cmpl2_num = '0;
  endtask

  // lands 1 ns after the falling edge: state is settled, inputs may change
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_disp(input rob_entry_t e1, input rob_entry_t e2);
    rob_bus.ds_to_rob_valid = 1'b1;
    rob_bus.map_to_rob_bus1 = e1;
    rob_bus.map_to_rob_bus2 = e2;
    if (m_count <= 14) begin
      if (e1.state != Inst_Invalid) begin
        sb_q.push_back(e1.pc);
        if (e1.state == Inst_Wait) cmpl_q.push_back(m_tail);
        m_tail++; m_count++;
      end
      if (e2.state != Inst_Invalid) begin
        sb_q.push_back(e2.pc);
        if (e2.state == Inst_Wait) cmpl_q.push_back(m_tail);
        m_tail++; m_count++;
      end
    end
  endtask

  // scoreboard: retirements are checked against dispatch order
  always @(negedge clk) begin
    #3;
    if (mon_en && !resetn) begin
      n_checks++;
      if ({rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_no_commit: c1=%b c2=%b flush=%b required 000",
                 rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o);
      end
    end else if (mon_en) begin
      if (rob_bus.commit1_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL commit1_order: pc=%h retired, nothing expected", rob_bus.commit1_entry.pc);
        end else begin
          mon_exp = sb_q.pop_front();
          if (rob_bus.commit1_entry.pc !== mon_exp) begin
            n_fail++;
            $display("FAIL commit1_order: pc=%h required %h", rob_bus.commit1_entry.pc, mon_exp);
          end
        end
        m_head++; m_count--;
      end
      if (rob_bus.commit2_valid === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL commit2_order: pc=%h retired, nothing expected", rob_bus.commit2_entry.pc);
        end else begin
          mon_exp = sb_q.pop_front();
          if (rob_bus.commit2_entry.pc !== mon_exp) begin
            n_fail++;
            $display("FAIL commit2_order: pc=%h required %h", rob_bus.commit2_entry.pc, mon_exp);
          end
        end
        m_head++; m_count--;
      end
      if (rob_bus.flush_o === 1'b1) begin
        sb_q.delete(); cmpl_q.delete();
        m_head = '0; m_tail = '0; m_count = 0;
      end
    end
  end

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      step(); idle();
      if (m_count == 0) done = 1'b1;
      else begin
        if (cmpl_q.size() > 0) begin rob_bus.cmpl1_valid = 1'b1; rob_bus.cmpl1_num = cmpl_q.pop_front(); end
        if (cmpl_q.size() > 0) begin rob_bus.cmpl2_valid = 1'b1; rob_bus.cmpl2_num = cmpl_q.pop_front(); end
      end
    end
    n_checks++;
    if (!done || dut.count !== 5'd0 || dut.head !== m_head) begin
      n_fail++;
      $display("FAIL drain: done=%0d count=%0d head=%0d required done=1 count=0 head=%0d",
               done, dut.count, dut.head, m_head);
    end
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    mon_en = 1'b1;
    #2;
    n_checks++; if (rob_bus.rob_tail_o !== 4'd0) begin n_fail++; $display("FAIL reset_tail: got %0d required 0", rob_bus.rob_tail_o); end
    n_checks++; if (rob_bus.rob_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", rob_bus.rob_ready); end
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 000", {rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o}); end
    n_checks++; if (dut.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", dut.count); end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_out_of_order();
    step(); idle();
    drive_disp(mk(32'h100, Inst_Wait, 1'b0, 1'b0), mk(32'h104, Inst_Wait, 1'b0, 1'b0));
    cmpl_q.delete();
    step(); idle();
    n_checks++; if (rob_bus.rob_tail_o !== 4'd2) begin n_fail++; $display("FAIL ooo_tail: got %0d required 2", rob_bus.rob_tail_o); end
    n_checks++; if (dut.count !== 5'd2) begin n_fail++; $display("FAIL ooo_count: got %0d required 2", dut.count); end
    n_checks++; if (rob_bus.commit1_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_no_commit_a: got %b required 0", rob_bus.commit1_valid); end
    rob_bus.cmpl1_valid = 1'b1; rob_bus.cmpl1_num = 4'd1;
    step(); idle();
    n_checks++; if (rob_bus.commit1_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_no_commit_b: got %b required 0", rob_bus.commit1_valid); end
    rob_bus.cmpl2_valid = 1'b1; rob_bus.cmpl2_num = 4'd0;
    step(); idle();
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.commit2_valid} !== 2'b11) begin
      n_fail++; $display("FAIL ooo_dual_commit: got %b required 11", {rob_bus.commit1_valid, rob_bus.commit2_valid}); end
    step();
    n_checks++; if (dut.head !== 4'd2 || dut.count !== 5'd0) begin
      n_fail++; $display("FAIL ooo_head: head=%0d count=%0d required head=2 count=0", dut.head, dut.count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 7; i++) begin
      step(); idle();
      n_checks++; if (rob_bus.rob_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b required 1", i, rob_bus.rob_ready); end
      drive_disp(mk(32'h200 + 32'(8*i), Inst_Wait, 1'b0, 1'b0), mk(32'h204 + 32'(8*i), Inst_Wait, 1'b0, 1'b0));
    end
    step(); idle();
    n_checks++; if (rob_bus.rob_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_14: got %b required 1", rob_bus.rob_ready); end
    drive_disp(mk(32'h240, Inst_Wait, 1'b0, 1'b0), '0);
    step(); idle();
    n_checks++; if (dut.count !== 5'd15) begin n_fail++; $display("FAIL fill_count15: got %0d required 15", dut.count); end
    n_checks++; if (rob_bus.rob_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_15: got %b required 0", rob_bus.rob_ready); end
    drive_disp(mk(32'h2f0, Inst_Wait, 1'b0, 1'b0), mk(32'h2f4, Inst_Wait, 1'b0, 1'b0));
    step(); idle();
    n_checks++; if (rob_bus.rob_tail_o !== 4'd1 || dut.count !== 5'd15) begin
      n_fail++; $display("FAIL fill_blocked: tail=%0d count=%0d required tail=1 count=15", rob_bus.rob_tail_o, dut.count); end
    drain(40);
  endtask

  task automatic test_exception_flush();
    step(); idle();
    drive_disp(mk(32'h300, Inst_Complete, 1'b1, 1'b0), mk(32'h304, Inst_Complete, 1'b0, 1'b0));
    step(); idle();
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.flush_o, rob_bus.commit2_valid} !== 3'b110) begin
      n_fail++; $display("FAIL exc_flush: c1,flush,c2=%b required 110", {rob_bus.commit1_valid, rob_bus.flush_o, rob_bus.commit2_valid}); end
    n_checks++; if (rob_bus.flush_exception !== 6'b1_00011) begin
      n_fail++; $display("FAIL exc_cause: got %b required 100011", rob_bus.flush_exception); end
    drive_disp(mk(32'h308, Inst_Wait, 1'b0, 1'b0), '0);
    step(); idle();
    n_checks++; if (dut.count !== 5'd0 || rob_bus.rob_tail_o !== 4'd0 || dut.head !== 4'd0 || rob_bus.commit1_valid !== 1'b0) begin
      n_fail++; $display("FAIL exc_after: count=%0d tail=%0d head=%0d c1=%b required 0 0 0 0",
                         dut.count, rob_bus.rob_tail_o, dut.head, rob_bus.commit1_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      step(); idle();
      drive_disp(mk(32'h400 + 32'(8*i), Inst_Complete, 1'b0, 1'b0), mk(32'h404 + 32'(8*i), Inst_Complete, 1'b0, 1'b0));
    end
    step(); idle();
    drive_disp(mk(32'h440, Inst_Complete, 1'b0, 1'b0), '0);
    drain(20);
    n_checks++; if (dut.head !== 4'd15 || rob_bus.rob_tail_o !== 4'd15) begin
      n_fail++; $display("FAIL wrap_setup: head=%0d tail=%0d required 15 15", dut.head, rob_bus.rob_tail_o); end
    drive_disp(mk(32'h500, Inst_Wait, 1'b0, 1'b0), mk(32'h504, Inst_Wait, 1'b0, 1'b0));
    step(); idle();
    n_checks++; if (dut.entries[15].pc !== 32'h500 || dut.entries[0].pc !== 32'h504) begin
      n_fail++; $display("FAIL wrap_slots: e15=%h e0=%h required 500 504", dut.entries[15].pc, dut.entries[0].pc); end
    drain(10);
    n_checks++; if (dut.head !== 4'd1 || rob_bus.rob_tail_o !== 4'd1) begin
      n_fail++; $display("FAIL wrap_end: head=%0d tail=%0d required 1 1", dut.head, rob_bus.rob_tail_o); end
  endtask

  task automatic test_store_pair();
    step(); idle();
    drive_disp(mk(32'h600, Inst_Complete, 1'b0, 1'b1), mk(32'h604, Inst_Complete, 1'b0, 1'b1));
    step(); idle();
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.commit2_valid} !== 2'b10 || rob_bus.commit1_entry.pc !== 32'h600) begin
      n_fail++; $display("FAIL store_first: c1c2=%b pc=%h required 10 600",
                         {rob_bus.commit1_valid, rob_bus.commit2_valid}, rob_bus.commit1_entry.pc); end
    step(); idle();
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.commit2_valid} !== 2'b10 || rob_bus.commit1_entry.pc !== 32'h604) begin
      n_fail++; $display("FAIL store_second: c1c2=%b pc=%h required 10 604",
                         {rob_bus.commit1_valid, rob_bus.commit2_valid}, rob_bus.commit1_entry.pc); end
    step();
    n_checks++; if (rob_bus.commit1_valid !== 1'b0 || dut.count !== 5'd0) begin
      n_fail++; $display("FAIL store_done: c1=%b count=%0d required 0 0", rob_bus.commit1_valid, dut.count); end
  endtask

  task automatic test_reset_midflight();
    step(); idle();
    drive_disp(mk(32'h700, Inst_Wait, 1'b0, 1'b0), mk(32'h704, Inst_Wait, 1'b0, 1'b0));
    step(); idle();
    drive_disp(mk(32'h708, Inst_Wait, 1'b0, 1'b0), mk(32'h70c, Inst_Wait, 1'b0, 1'b0));
    step(); idle();
    drive_disp(mk(32'h710, Inst_Wait, 1'b0, 1'b0), '0);
    step(); idle();
    n_checks++; if (dut.count !== 5'd5) begin n_fail++; $display("FAIL mid_count: got %0d required 5", dut.count); end
    rob_bus.cmpl1_valid = 1'b1; rob_bus.cmpl1_num = cmpl_q[0];
    resetn = 1'b0;
    sb_q.delete(); cmpl_q.delete();
    m_head = '0; m_tail = '0; m_count = 0;
    #1;
    n_checks++; if (rob_bus.rob_tail_o !== 4'd0 || rob_bus.rob_ready !== 1'b1 || dut.count !== 5'd0) begin
      n_fail++; $display("FAIL mid_reset_state: tail=%0d ready=%b count=%0d required 0 1 0",
                         rob_bus.rob_tail_o, rob_bus.rob_ready, dut.count); end
    n_checks++; if ({rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b required 000", {rob_bus.commit1_valid, rob_bus.commit2_valid, rob_bus.flush_o}); end
    step(); idle();
    step();
    resetn = 1'b1;
    step(); idle();
    drive_disp(mk(32'h800, Inst_Wait, 1'b0, 1'b0), mk(32'h804, Inst_Wait, 1'b0, 1'b0));
    drain(10);
  endtask

  initial begin
    test_reset();
    test_out_of_order();
    test_fill();
    test_exception_flush();
    test_wrap();
    test_store_pair();
    test_reset_midflight();
    step();
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left required 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries (power of two).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, log2(ROB_DEPTH), entry index width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ds_to_rob_valid  in  1  the decode stage offers dispatch entries this cycle.
REQ-006 SHALL have port map_to_rob_bus1  in  rob_entry_t  first dispatched entry; state Inst_Invalid means empty slot.
REQ-007 SHALL have port map_to_rob_bus2  in  rob_entry_t  second dispatched entry; non-invalid only if bus1 is non-invalid.
REQ-008 SHALL have port rob_tail_o  out  ROB_IDX_W  index the next dispatched entry will occupy.
REQ-009 SHALL have port rob_ready  out  1  at least two free entries.
REQ-010 SHALL have ports cmpl1_valid and cmpl2_valid  in  1 each  execution completion strobes.
REQ-011 SHALL have ports cmpl1_num and cmpl2_num  in  ROB_IDX_W each  completing entry index.
REQ-012 SHALL have ports commit1_valid and commit2_valid  out  1 each  in-order retirement strobes.
REQ-013 SHALL have ports commit1_entry and commit2_entry  out  rob_entry_t each  retiring entry contents.
REQ-014 SHALL have port flush_o  out  1  exception flush pulse.
REQ-015 SHALL have port flush_exception  out  exception_t  exception of the flushing entry.

Function
REQ-016 Storage SHALL be a circular array of ROB_DEPTH rob_entry_t, with head and tail pointers of ROB_IDX_W bits and a count of ROB_IDX_W+1 bits.
REQ-017 Dispatch SHALL occur only when ds_to_rob_valid and rob_ready are both 1 and flush_o is 0: bus1 is written at tail, bus2 at tail+1 (mod ROB_DEPTH); Inst_Invalid slots are not written.
REQ-018 Tail SHALL advance by the number of non-invalid dispatched slots (0, 1 or 2), wrapping modulo ROB_DEPTH.
REQ-019 An entry dispatched with state Inst_Complete (exception at decode) SHALL need no completion.
REQ-020 A completion strobe whose entry is in Inst_Wait SHALL set that entry to Inst_Complete at the next edge; a strobe to an Inst_Invalid entry SHALL be ignored; two strobes in one cycle SHALL both take effect.
REQ-021 commit1_valid SHALL be 1 combinationally when the head entry is Inst_Complete.
REQ-022 commit2_valid SHALL be 1 when commit1_valid is 1, head+1 is Inst_Complete, neither entry has exception.ex set, and they are not both store ops.
REQ-023 commit1_entry and commit2_entry SHALL be the head and head+1 entries.
REQ-024 Committed entries SHALL become Inst_Invalid, and head SHALL advance by the commit count.
REQ-025 When the head entry commits with exception.ex set, flush_o SHALL be 1 in that cycle, flush_exception SHALL carry its exception, and commit2_valid SHALL be 0.
REQ-026 At the edge ending a flush cycle, all entries SHALL become Inst_Invalid, head, tail and count SHALL become 0, and same-cycle dispatch and completions SHALL be dropped.
REQ-027 Count SHALL update as count + dispatched - committed, with simultaneous dispatch and commit allowed, including at full (16) and empty (0).
REQ-028 rob_ready SHALL be (ROB_DEPTH - count) >= 2; with 15 entries occupied it SHALL be 0.
REQ-029 A completion and a commit cannot hit the same entry in one cycle: commit uses the registered state, so a completing entry commits no earlier than the next cycle.
REQ-030 Dispatch while rob_ready is 0 SHALL be ignored and flagged by a simulation assertion.

Reset
REQ-031 While resetn is 0, asynchronously: all entries Inst_Invalid, head, tail and count 0, rob_tail_o 0, rob_ready 1, commit and flush outputs 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries without any commit pulse.

Structure
REQ-033 rob_entry_t, the inst state enum (Inst_Invalid, Inst_Wait, Inst_Complete), exception_t and ROB_DEPTH SHALL live in the shared cpu package.
REQ-034 An optional sub-module rob_commit_sel SHALL hold the combinational commit and flush selection; storage and pointers stay in the top module.

Verification
REQ-035 From reset, dispatch two entries, complete index 1 then index 0 -> no commit until index 0 completes, then commit1 and commit2 in the same cycle; head is 2.
REQ-036 Fill 16 entries without completing any -> rob_ready drops when count reaches 15; a dispatch attempt while not ready leaves tail unchanged and fires the assertion.
REQ-037 Dispatch entry 0 with exception.ex=1 -> next cycle commit1_valid=1, flush_o=1, commit2_valid=0; following cycle count=0 and tail=0.
REQ-038 Head at 15, tail at 15: dispatch two, complete both -> entries land at 15 and 0; both commit; head=tail=1.
REQ-039 Two complete store ops at head and head+1 -> only commit1 in the first cycle, commit1 of the second store in the next cycle.
REQ-040 Deassert resetn with 5 entries in flight -> all outputs read reset values immediately, with no commit pulse.
